// File: rtl/vga_timing_gen.sv
// Pixel/line counters and registered VGA pin outputs (sync + blanked colour).
// Everything advances on pix_en; pins lag the counters by one pixel slot.
module vga_timing_gen #(
  parameter int   H_VIS  = 1440,
  parameter int   H_FP   = 80,
  parameter int   H_SYNC = 152,
  parameter int   H_BP   = 232,
  parameter int   V_VIS  = 900,
  parameter int   V_FP   = 1,
  parameter int   V_SYNC = 3,
  parameter int   V_BP   = 28,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  output logic [10:0] draw_x,
  output logic [9:0]  draw_y,
  output logic        video_on,
  output logic        frame_tick,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] X_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] X_VIS      = 11'(H_VIS);
  localparam logic [10:0] HS_FIRST   = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_LAST    = 11'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]  Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_VIS      = 10'(V_VIS);
  localparam logic [9:0]  VS_FIRST   = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [3:0]  r_q, r_d;
  logic [3:0]  g_q, g_d;
  logic [3:0]  b_q, b_d;

  assign video_on = (x_q < X_VIS) && (y_q < Y_VIS);

  // Combinational so the pulse is exactly one clock wide and coincides with (0, V_VIS).
  assign frame_tick = pix_en && !rst && (x_q == 11'd0) && (y_q == Y_VIS);

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    hs_d = hs_q;
    vs_d = vs_q;
    r_d  = r_q;
    g_d  = g_q;
    b_d  = b_q;
    if (pix_en) begin
      if (x_q == X_LAST) begin
        x_d = 11'd0;
        y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
      hs_d = ((x_q >= HS_FIRST) && (x_q <= HS_LAST)) ? H_POL : ~H_POL;
      vs_d = ((y_q >= VS_FIRST) && (y_q <= VS_LAST)) ? V_POL : ~V_POL;
      r_d  = video_on ? r_in : 4'h0;
      g_d  = video_on ? g_in : 4'h0;
      b_d  = video_on ? b_in : 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q  <= 11'd0;
      y_q  <= 10'd0;
      hs_q <= ~H_POL;
      vs_q <= ~V_POL;
      r_q  <= 4'h0;
      g_q  <= 4'h0;
      b_q  <= 4'h0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
    end
  end

  assign draw_x = x_q;
  assign draw_y = y_q;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  assign vga_r  = r_q;
  assign vga_g  = g_q;
  assign vga_b  = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunk raster; the model tracks a linear
// pixel-slot index and derives position and pin values arithmetically.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HS = 3, HB = 4;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic HP = 1'b0;
  localparam logic VP = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_en = 1'b0;
  logic [3:0]  r_in = 4'h0, g_in = 4'h0, b_in = 4'h0;
  logic [10:0] draw_x;
  logic [9:0]  draw_y;
  logic        video_on, frame_tick, vga_hs, vga_vs;
  logic [3:0]  vga_r, vga_g, vga_b;

  vga_timing_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HP), .V_POL(VP)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .draw_x(draw_x), .draw_y(draw_y), .video_on(video_on), .frame_tick(frame_tick),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: n = pixel slots elapsed in the current frame.
  int         n = 0;
  logic       e_hs = ~HP, e_vs = ~VP;
  logic [3:0] e_r = 4'h0, e_g = 4'h0, e_b = 4'h0;
  logic       obs_vo, obs_ft, exp_vo, exp_ft;
  logic [3:0] last_r, last_g, last_b;

  task automatic step(input logic pe, input logic rs);
    int x, y;
    logic vis;
    pix_en = pe;
    rst    = rs;
    r_in   = 4'($urandom_range(1, 15));
    g_in   = 4'($urandom_range(1, 15));
    b_in   = 4'($urandom_range(1, 15));
    last_r = r_in; last_g = g_in; last_b = b_in;
    x = n % HT;
    y = n / HT;
    vis = (x < HV) && (y < VV);
    #1;
    obs_vo = video_on;
    obs_ft = frame_tick;
    exp_vo = vis;
    exp_ft = pe && !rs && (x == 0) && (y == VV);
    @(posedge clk);
    #1;
    if (rs) begin
      n = 0;
      e_hs = ~HP; e_vs = ~VP;
      e_r = 4'h0; e_g = 4'h0; e_b = 4'h0;
    end else if (pe) begin
      e_hs = (x >= HV + HF && x < HV + HF + HS) ? HP : ~HP;
      e_vs = (y >= VV + VF && y < VV + VF + VS) ? VP : ~VP;
      e_r = vis ? last_r : 4'h0;
      e_g = vis ? last_g : 4'h0;
      e_b = vis ? last_b : 4'h0;
      n = (n + 1) % FRAME;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1);
      checks++;
      if ({draw_x, draw_y} !== 21'd0) begin
        errors++; $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", draw_x, draw_y);
      end
      checks++;
      if ({vga_hs, vga_vs} !== {~HP, ~VP}) begin
        errors++; $display("FAIL reset_sync: got hs=%b vs=%b want %b %b", vga_hs, vga_vs, ~HP, ~VP);
      end
      checks++;
      if ({vga_r, vga_g, vga_b} !== 12'h000) begin
        errors++; $display("FAIL reset_rgb: got %h want 000", {vga_r, vga_g, vga_b});
      end
      checks++;
      if (obs_ft !== 1'b0) begin
        errors++; $display("FAIL reset_tick: got %b want 0", obs_ft);
      end
    end
  endtask

  task automatic test_first_after_reset();
    step(1'b0, 1'b0);
    checks++;
    if ({draw_x, draw_y} !== 21'd0) begin
      errors++; $display("FAIL idle_after_reset: got x=%0d y=%0d want 0 0", draw_x, draw_y);
    end
    step(1'b1, 1'b0);
    checks++;
    if (draw_x !== 11'd1 || draw_y !== 10'd0) begin
      errors++; $display("FAIL first_advance: got x=%0d y=%0d want 1 0", draw_x, draw_y);
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== {last_r, last_g, last_b}) begin
      errors++; $display("FAIL first_colour: got %h want %h", {vga_r, vga_g, vga_b}, {last_r, last_g, last_b});
    end
  endtask

  // mode 0: pix_en always, 1: every 4th clock, 2: random
  task automatic test_stream(input string name, input int ncyc, input int mode);
    int ft_obs = 0, ft_exp = 0, last_tick = -1;
    logic pe;
    for (int i = 0; i < ncyc; i++) begin
      pe = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 4 == 3) : 1'($urandom_range(0, 1));
      step(pe, 1'b0);
      checks++;
      if (obs_vo !== exp_vo) begin
        errors++; $display("FAIL %s video_on cyc %0d: got %b want %b", name, i, obs_vo, exp_vo);
      end
      checks++;
      if (obs_ft !== exp_ft) begin
        errors++; $display("FAIL %s frame_tick cyc %0d: got %b want %b", name, i, obs_ft, exp_ft);
      end
      checks++;
      if (draw_x !== 11'(n % HT) || draw_y !== 10'(n / HT)) begin
        errors++; $display("FAIL %s xy cyc %0d: got %0d,%0d want %0d,%0d", name, i, draw_x, draw_y, n % HT, n / HT);
      end
      checks++;
      if (vga_hs !== e_hs || vga_vs !== e_vs) begin
        errors++; $display("FAIL %s sync cyc %0d: got hs=%b vs=%b want %b %b", name, i, vga_hs, vga_vs, e_hs, e_vs);
      end
      checks++;
      if ({vga_r, vga_g, vga_b} !== {e_r, e_g, e_b}) begin
        errors++; $display("FAIL %s rgb cyc %0d: got %h want %h", name, i, {vga_r, vga_g, vga_b}, {e_r, e_g, e_b});
      end
      if (obs_ft === 1'b1) begin
        if (last_tick >= 0 && mode != 2) begin
          checks++;
          if (i - last_tick != ((mode == 0) ? FRAME : 4 * FRAME)) begin
            errors++; $display("FAIL %s frame_period: got %0d want %0d", name, i - last_tick, (mode == 0) ? FRAME : 4 * FRAME);
          end
        end
        last_tick = i;
        ft_obs++;
      end
      if (exp_ft) ft_exp++;
    end
    checks++;
    if (ft_obs != ft_exp) begin
      errors++; $display("FAIL %s tick_count: got %0d want %0d", name, ft_obs, ft_exp);
    end
  endtask

  task automatic test_midframe_reset();
    int k = 0;
    while (!((n % HT) == HV + HF + 1 && (n / HT) == VV + VF) && k < 2 * FRAME) begin
      step(1'b1, 1'b0);
      k++;
    end
    checks++;
    if (k >= 2 * FRAME) begin
      errors++; $display("FAIL midreset_reach: got timeout want position %0d,%0d", HV + HF + 1, VV + VF);
    end
    step(1'b1, 1'b0);
    checks++;
    if (vga_hs !== HP || vga_vs !== VP) begin
      errors++; $display("FAIL midreset_pulse: got hs=%b vs=%b want %b %b", vga_hs, vga_vs, HP, VP);
    end
    step(1'b1, 1'b1);
    checks++;
    if ({draw_x, draw_y} !== 21'd0) begin
      errors++; $display("FAIL midreset_xy: got %0d,%0d want 0,0", draw_x, draw_y);
    end
    checks++;
    if (vga_hs !== ~HP || vga_vs !== ~VP) begin
      errors++; $display("FAIL midreset_sync: got hs=%b vs=%b want %b %b", vga_hs, vga_vs, ~HP, ~VP);
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      errors++; $display("FAIL midreset_rgb: got %h want 000", {vga_r, vga_g, vga_b});
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_first_after_reset();
    test_stream("free_run", 2 * FRAME + 10, 0);
    test_stream("sparse", 2 * 4 * FRAME + 8, 1);
    test_stream("random", 600, 2);
    test_midframe_reset();
    test_stream("after_midreset", FRAME + 5, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
